// File: rtl/esp_power_sequencer.sv
// ESP8266 power/reset sequencer: timed CH_PD and RST pin control, readiness
// reporting and an optional UART-liveness watchdog that forces a module reset.
module esp_power_sequencer #(
  parameter int unsigned PWR_CYCLES  = 500000,
  parameter int unsigned RST_CYCLES  = 50000,
  parameter int unsigned BOOT_CYCLES = 25000000,
  parameter int unsigned WDOG_CYCLES = 0,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       pwr_on,
  input  logic       rst_req,
  input  logic       alive,
  output logic       mod_en,
  output logic       mod_rst,
  output logic       ready,
  output logic       busy,
  output logic       wdog_evt,
  output logic [7:0] rst_count
);

  typedef enum logic [2:0] {
    S_OFF,
    S_PWR_UP,
    S_RST_LOW,
    S_BOOT_WAIT,
    S_READY
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = (WDOG_CYCLES == 0) ? '0 : CNT_W'(WDOG_CYCLES - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mod_en;
  logic               r_mod_rst;
  logic               r_ready;
  logic               r_busy;
  logic               r_wdog_evt;
  logic [7:0]         r_rst_count;

  state_t             w_next;
  logic               w_wdog_fire;
  logic               w_enter_rst;
  logic               w_cnt_clr;

  always_comb begin
    w_next      = r_state;
    w_wdog_fire = 1'b0;
    if (!pwr_on) begin
      w_next = S_OFF;
    end else begin
      case (r_state)
        S_OFF:     w_next = S_PWR_UP;
        S_PWR_UP:  if (r_cnt == PWR_LAST) w_next = S_BOOT_WAIT;
        S_RST_LOW: if (r_cnt == RST_LAST) w_next = S_BOOT_WAIT;
        S_BOOT_WAIT: begin
          if (rst_req)                 w_next = S_RST_LOW;
          else if (r_cnt == BOOT_LAST) w_next = S_READY;
        end
        S_READY: begin
          // A same-edge alive pulse rescues the module from the watchdog.
          if (rst_req) begin
            w_next = S_RST_LOW;
          end else if ((WDOG_CYCLES != 0) && !alive && (r_cnt == WDOG_LAST)) begin
            w_next      = S_RST_LOW;
            w_wdog_fire = 1'b1;
          end
        end
        default:   w_next = S_OFF;
      endcase
    end
  end

  assign w_enter_rst = (w_next == S_RST_LOW) && (r_state != S_RST_LOW);
  assign w_cnt_clr   = (w_next != r_state) || (w_next == S_OFF) ||
                       ((r_state == S_READY) && alive);

  // Outputs are registered from the next state so they change on the entry edge.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state     <= S_OFF;
      r_cnt       <= '0;
      r_mod_en    <= 1'b0;
      r_mod_rst   <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_wdog_evt  <= 1'b0;
      r_rst_count <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      r_mod_en   <= (w_next != S_OFF);
      r_mod_rst  <= (w_next == S_BOOT_WAIT) || (w_next == S_READY);
      r_ready    <= (w_next == S_READY);
      r_busy     <= (w_next == S_PWR_UP) || (w_next == S_RST_LOW) || (w_next == S_BOOT_WAIT);
      r_wdog_evt <= w_wdog_fire;
      if (w_enter_rst && (r_rst_count != 8'hFF)) begin
        r_rst_count <= r_rst_count + 8'd1;
      end
    end
  end

  assign mod_en    = r_mod_en;
  assign mod_rst   = r_mod_rst;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign wdog_evt  = r_wdog_evt;
  assign rst_count = r_rst_count;

endmodule

// File: tb/tb_esp_power_sequencer.sv
// Scoreboard bench for esp_power_sequencer: a countdown model predicts the
// output vector each edge, plus direct edge-by-edge checks of key timings.
module tb_esp_power_sequencer;

  localparam int PWR  = 4;
  localparam int RST  = 3;
  localparam int BOOT = 8;
  localparam int WDOG = 10;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       pwr_on = 1'b0;
  logic       rst_req = 1'b0;
  logic       alive = 1'b0;
  logic       mod_en, mod_rst, ready, busy, wdog_evt;
  logic [7:0] rst_count;

  int checks = 0;
  int failures = 0;

  esp_power_sequencer #(
    .PWR_CYCLES (PWR),
    .RST_CYCLES (RST),
    .BOOT_CYCLES(BOOT),
    .WDOG_CYCLES(WDOG),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .pwr_on   (pwr_on),
    .rst_req  (rst_req),
    .alive    (alive),
    .mod_en   (mod_en),
    .mod_rst  (mod_rst),
    .ready    (ready),
    .busy     (busy),
    .wdog_evt (wdog_evt),
    .rst_count(rst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Countdown-style reference model
  typedef enum int {M_OFF, M_PWR, M_RST, M_BOOT, M_RDY} mst_t;
  mst_t m_st = M_OFF;
  int   m_left = 0;
  int   m_wd = 0;
  int   m_cnt = 0;
  logic m_evt = 1'b0;
  logic [12:0] sb_q[$];

  task automatic model_enter_rst();
    m_st   = M_RST;
    m_left = RST;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic model_edge(input logic p, input logic r, input logic a);
    m_evt = 1'b0;
    if (!p) begin
      m_st = M_OFF;
    end else begin
      case (m_st)
        M_OFF: begin m_st = M_PWR; m_left = PWR; end
        M_PWR: if (m_left == 1) begin m_st = M_BOOT; m_left = BOOT; end else m_left--;
        M_RST: if (m_left == 1) begin m_st = M_BOOT; m_left = BOOT; end else m_left--;
        M_BOOT: begin
          if (r) model_enter_rst();
          else if (m_left == 1) begin m_st = M_RDY; m_wd = WDOG; end
          else m_left--;
        end
        M_RDY: begin
          if (r) model_enter_rst();
          else if (a) m_wd = WDOG;
          else if (m_wd == 1) begin model_enter_rst(); m_evt = 1'b1; end
          else m_wd--;
        end
        default: m_st = M_OFF;
      endcase
    end
  endtask

  function automatic logic [12:0] model_vec();
    logic en, rs, rd, bz;
    en = (m_st != M_OFF);
    rs = (m_st == M_BOOT) || (m_st == M_RDY);
    rd = (m_st == M_RDY);
    bz = (m_st == M_PWR) || (m_st == M_RST) || (m_st == M_BOOT);
    return {en, rs, rd, bz, m_evt, m_cnt[7:0]};
  endfunction

  // Drive one edge's inputs, push the prediction, compare after the edge.
  task automatic step(input logic p, input logic r, input logic a, input string tag);
    logic [12:0] exp_v;
    pwr_on  = p;
    rst_req = r;
    alive   = a;
    model_edge(p, r, a);
    sb_q.push_back(model_vec());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp_v = sb_q.pop_front();
      chk({tag, "_sb"}, {19'd0, mod_en, mod_rst, ready, busy, wdog_evt, rst_count}, {19'd0, exp_v});
      $display("edge %s p=%0b r=%0b a=%0b out=%0h", tag, p, r, a,
               {mod_en, mod_rst, ready, busy, wdog_evt, rst_count});
    end
  endtask

  // Assert sys_rst between edges and check outputs clear without a clock.
  task automatic async_reset(input string tag);
    #3;
    sys_rst = 1'b0;
    #1;
    chk({tag, "_outs"}, {19'd0, mod_en, mod_rst, ready, busy, wdog_evt, rst_count}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, rst_count}, 32'd0);
    m_st  = M_OFF;
    m_cnt = 0;
    m_evt = 1'b0;
    sb_q.delete();
    #1;
    sys_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic saw_evt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {19'd0, mod_en, mod_rst, ready, busy, wdog_evt, rst_count}, 32'd0);
    sys_rst = 1'b1;

    // Power-up then commanded reset at edge 20, ignored repeat at 21
    for (int e = 0; e <= 31; e++) begin
      step(1'b1, (e == 20) || (e == 21), 1'b0, $sformatf("pu%0d", e));
      if (e == 0)  begin chk("pu_en_e0", mod_en, 1); chk("pu_busy_e0", busy, 1); chk("pu_rst_e0", mod_rst, 0); end
      if (e == 3)  chk("pu_rst_e3", mod_rst, 0);
      if (e == 4)  chk("pu_rst_e4", mod_rst, 1);
      if (e == 11) begin chk("pu_rdy_e11", ready, 0); chk("pu_busy_e11", busy, 1); end
      if (e == 12) begin chk("pu_rdy_e12", ready, 1); chk("pu_busy_e12", busy, 0); end
      if (e == 19) chk("pu_cnt_e19", rst_count, 0);
      if (e == 20) begin chk("cr_rst_e20", mod_rst, 0); chk("cr_rdy_e20", ready, 0); end
      if (e == 22) chk("cr_rst_e22", mod_rst, 0);
      if (e == 23) chk("cr_rst_e23", mod_rst, 1);
      if (e == 30) chk("cr_rdy_e30", ready, 0);
      if (e == 31) begin chk("cr_rdy_e31", ready, 1); chk("cr_cnt_e31", rst_count, 1); end
    end

    // Watchdog: READY from edge 31, silent link fires ten edges later
    for (int e = 32; e <= 52; e++) begin
      step(1'b1, 1'b0, 1'b0, $sformatf("wd%0d", e));
      if (e == 40) chk("wd_evt_e40", wdog_evt, 0);
      if (e == 41) begin chk("wd_evt_e41", wdog_evt, 1); chk("wd_rst_e41", mod_rst, 0); end
      if (e == 42) chk("wd_evt_e42", wdog_evt, 0);
      if (e == 43) chk("wd_rst_e43", mod_rst, 0);
      if (e == 44) begin chk("wd_rst_e44", mod_rst, 1); chk("wd_cnt_e44", rst_count, 2); end
      if (e == 52) chk("wd_rdy_e52", ready, 1);
    end

    saw_evt = 1'b0;
    for (int j = 0; j < 100; j++) begin
      step(1'b1, 1'b0, (j % 5) == 0, $sformatf("alv%0d", j));
      if (wdog_evt) saw_evt = 1'b1;
    end
    chk("alv_no_evt", saw_evt, 0);
    chk("alv_rdy", ready, 1);
    chk("alv_cnt", rst_count, 2);

    // Power loss mid BOOT_WAIT, then power loss together with rst_req
    step(1'b0, 1'b0, 1'b0, "off");
    chk("off_en", mod_en, 0);
    for (int e = 0; e <= 6; e++) begin
      step(e < 6, 1'b0, 1'b0, $sformatf("pl%0d", e));
      if (e == 5) chk("pl_rst_e5", mod_rst, 1);
      if (e == 6) begin chk("pl_en_e6", mod_en, 0); chk("pl_rst_e6", mod_rst, 0); chk("pl_busy_e6", busy, 0); end
    end
    for (int e = 0; e <= 6; e++) begin
      step(e < 6, e == 6, 1'b0, $sformatf("plr%0d", e));
    end
    chk("plr_en", mod_en, 0);
    chk("plr_cnt", rst_count, 2);

    // Async reset while in RST_LOW
    for (int e = 0; e <= 14; e++) begin
      step(1'b1, e == 13, 1'b0, $sformatf("ar%0d", e));
    end
    chk("ar_pre_cnt", rst_count, 3);
    async_reset("ar");

    // Saturation: 300 commanded resets from BOOT_WAIT
    for (int e = 0; e <= 4; e++) begin
      step(1'b1, e == 2, 1'b0, $sformatf("sat_pu%0d", e));
    end
    chk("sat_pwrup_req_dropped", rst_count, 0);
    for (int n = 0; n < 300; n++) begin
      step(1'b1, 1'b1, 1'b0, $sformatf("sat%0d_req", n));
      for (int k = 1; k <= 3; k++) begin
        step(1'b1, 1'b0, 1'b0, $sformatf("sat%0d_%0d", n, k));
      end
      if (n == 9) chk("sat_cnt_10", rst_count, 10);
    end
    chk("sat_cnt_255", rst_count, 255);
    async_reset("sat_ar");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
